sha256_padder: RTL
==================

Name: sha256_padder

Overview:
- Upstream message stage for the SHA-256 core.
- Accepts a 32-bit big-endian word stream with valid/ready and assembles 512-bit blocks in a 16-word buffer.
- Appends FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length) and drives the core's init/next/block interface.
- Reports completion of each message once the core's final digest is valid.

Parameters:
- LEN_W, 64: width of the message bit-length counter; values narrower than 64 are zero-extended into the length field; the counter wraps modulo 2^LEN_W.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  padder accepts a word this cycle
- in_data  in  32  message word; byte 0 is in_data[31:24]
- in_last  in  1  final word of the message
- in_keep  in  3  valid bytes in the final word, 0..4; 0 allowed only for an empty message; ignored when in_last=0 (treated as 4)
- core_init  out  1  one-cycle start pulse for the first block of a message
- core_next  out  1  one-cycle start pulse for each subsequent block
- core_block  out  512  assembled block; word 0 is in bits [511:480]
- core_ready  in  1  core idle
- core_digest_valid  in  1  core digest valid
- msg_done  out  1  one-cycle pulse: final block digest is valid on the core's digest
- busy  out  1  high in every state except FILL with an empty buffer and no message in progress

Behaviour:
- Reset values:
  - in_ready=0 during reset; in_ready=1 in the first cycle after reset.
  - core_init=0, core_next=0, msg_done=0, busy=0, core_block=0.
  - Counters, flags and state are cleared; state=FILL.
- Reset mid-operation aborts the message and clears the buffer. The core shares reset_n.
- Internal state:
  - wptr: 5 bits, range 0..16.
  - bitlen: LEN_W bits.
  - first_flag: set on reset and after msg_done.
  - pad_byte_done, final_flag.
- FILL:
  - in_ready=1; a word transfers when in_valid && in_ready.
  - Accept: buf[wptr] = in_data with bytes beyond keep zeroed; wptr++; bitlen += 8*keep.
  - If in_last and keep<4: the 0x80 byte is placed at byte position keep of the same word, and pad_byte_done=1.
  - Non-last word with wptr reaching 16 -> ISSUE.
  - Accepting in_last -> PAD.
- PAD: one action per cycle, with in_ready=0.
  - If !pad_byte_done and wptr==16 -> ISSUE (non-final block).
  - If !pad_byte_done and wptr<16: buf[wptr]=32'h80000000; wptr++; pad_byte_done=1.
  - If pad_byte_done and wptr<=14: buf[14]={upper 32 bits of length}, buf[15]={lower 32 bits}; final_flag=1 -> ISSUE.
  - If pad_byte_done and wptr>=15 -> ISSUE (non-final block; the next block holds zeros plus the length).
- ISSUE:
  - Waits while core_ready=0.
  - When core_ready=1: pulse core_init if first_flag, else core_next, for exactly one cycle -> WAIT.
- WAIT:
  - core_block is held stable from the ISSUE pulse until leaving WAIT.
  - Exit on core_ready && core_digest_valid. This condition cannot be satisfied on the pulse cycle because the core clears digest_valid on that edge.
  - On exit: buffer cleared to zero, wptr=0, first_flag=0.
  - If final_flag: msg_done=1 for one cycle; clear bitlen, flags and first_flag=1; go to FILL.
  - Else if in_last was accepted but padding is incomplete -> PAD; otherwise -> FILL.
- Unwritten buffer words are always zero, because the buffer is cleared after every block.
- Latency for a 1-block message: last word accept, +1 cycle PAD, +1 cycle ISSUE pulse, then the core's rounds, then msg_done on the cycle the digest becomes valid and ready returns.
- Throughput: one block in flight; no overlap with the core.
- in_keep>4, or in_keep=0 on a non-empty message: the value is clamped to 4, or treated as 0 bytes; not checked.

Optional Feature:
- SHA256_PAD_BYTE_SWAP_EN
- Defined: in_data is little-endian, with byte 0 in [7:0]; bytes are reversed before masking and storage.
- Undefined: in_data is used as-is (big-endian).
- Padding and the length field are unaffected in both cases.

Decomposition:
- Shared package sha256_pkg:
  - padder state enum (FILL, PAD, ISSUE, WAIT)
  - SHA256_BLOCK_W=512, SHA256_WORD_W=32, SHA256_LEN_FIELD_W=64
  - pad constant 32'h80000000
- One natural sub-module: sha256_pad_word, a combinational word masker. It performs byte swap, keep masking and 0x80 insertion.
- The FSM, buffer and counters stay in the top module.

Test Plan:
- "abc": one word 32'h61626300, keep=3, last -> one block with core_init only; buf[0]=32'h61626380, buf[15]=32'h18; digest ba7816bf...f20015ad; msg_done pulses once.
- Empty message, keep=0 -> buf[0]=32'h80000000, length 0; digest e3b0c442...7852b855.
- 56-byte "abcdbcde...nopq" -> two blocks (core_init then core_next); the second block is zeros plus length 0x1C0; digest 248d6a61...19db06c1.
- 55-byte message -> exactly one block; buf[13] ends in 0x80; length 0x1B8.
- 64-byte message -> the full block is issued before PAD; the second block starts with 32'h80000000; length 0x200.
- Backpressure and abort:
  - Random in_valid gaps with core_ready held low 5 cycles in ISSUE -> no extra pulses and core_block stable.
  - reset_n low mid-WAIT -> all outputs 0; the next message uses core_init.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 message padder
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } pad_state_t;

    localparam int SHA256_BLOCK_W     = 512;
    localparam int SHA256_WORD_W      = 32;
    localparam int SHA256_LEN_FIELD_W = 64;

    localparam logic [SHA256_WORD_W-1:0] SHA256_PAD_WORD = 32'h8000_0000;

    function automatic logic [2:0] clamp_keep(input logic [2:0] keep, input logic last);
        if (!last || keep > 3'd4)
            return 3'd4;
        return keep;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// rtl/sha256_pad_word.sv - word masker: optional byte swap (SHA256_PAD_BYTE_SWAP_EN), keep mask, 0x80 insert
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [SHA256_WORD_W-1:0] i_data,
    input  logic [2:0]               i_keep,
    input  logic                     i_last,
    output logic [SHA256_WORD_W-1:0] o_word,
    output logic [2:0]               o_nbytes,
    output logic                     o_pad_placed
);

    logic [SHA256_WORD_W-1:0] w_data;

`ifdef SHA256_PAD_BYTE_SWAP_EN
    assign w_data = {i_data[7:0], i_data[15:8], i_data[23:16], i_data[31:24]};
`else
    assign w_data = i_data;
`endif

    // Byte 0 sits in the top byte; the pad marker lands right after the last valid byte.
    always_comb begin
        o_nbytes     = clamp_keep(i_keep, i_last);
        o_pad_placed = i_last && (o_nbytes != 3'd4);
        o_word       = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(o_nbytes))
                o_word[31-8*b -: 8] = w_data[31-8*b -: 8];
            else if (o_pad_placed && b == int'(o_nbytes))
                o_word[31-8*b -: 8] = 8'h80;
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 block assembler and padder; SHA256_PAD_BYTE_SWAP_EN selects little-endian input
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SHA256_WORD_W-1:0]  in_data,
    input  logic                      in_last,
    input  logic [2:0]                in_keep,
    output logic                      core_init,
    output logic                      core_next,
    output logic [SHA256_BLOCK_W-1:0] core_block,
    input  logic                      core_ready,
    input  logic                      core_digest_valid,
    output logic                      msg_done,
    output logic                      busy
);

    pad_state_t                  r_state;
    logic [SHA256_WORD_W-1:0]    r_buf [16];
    logic [4:0]                  r_wptr;
    logic [LEN_W-1:0]            r_bitlen;
    logic                        r_first;
    logic                        r_pad_done;
    logic                        r_final;
    logic                        r_last_seen;
    logic                        r_in_ready;
    logic                        r_core_init;
    logic                        r_core_next;
    logic                        r_msg_done;

    logic [SHA256_WORD_W-1:0]      w_word;
    logic [2:0]                    w_nbytes;
    logic                          w_pad_placed;
    logic [SHA256_LEN_FIELD_W-1:0] w_len;
    logic                          w_pulse;

    sha256_pad_word u_pad_word (
        .i_data       (in_data),
        .i_keep       (in_keep),
        .i_last       (in_last),
        .o_word       (w_word),
        .o_nbytes     (w_nbytes),
        .o_pad_placed (w_pad_placed)
    );

    assign w_len   = SHA256_LEN_FIELD_W'(r_bitlen);
    assign w_pulse = r_core_init || r_core_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FILL;
            for (int i = 0; i < 16; i++)
                r_buf[i] <= '0;
            r_wptr      <= '0;
            r_bitlen    <= '0;
            r_first     <= 1'b1;
            r_pad_done  <= 1'b0;
            r_final     <= 1'b0;
            r_last_seen <= 1'b0;
            r_in_ready  <= 1'b0;
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            r_msg_done  <= 1'b0;
        end else begin
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            r_msg_done  <= 1'b0;
            case (r_state)
                FILL: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_buf[r_wptr[3:0]] <= w_word;
                        r_wptr             <= r_wptr + 5'd1;
                        r_bitlen           <= r_bitlen + LEN_W'({w_nbytes, 3'b000});
                        if (in_last) begin
                            r_pad_done  <= w_pad_placed;
                            r_last_seen <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= PAD;
                        end else if (r_wptr == 5'd15) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ISSUE;
                        end
                    end
                end
                PAD: begin
                    if (!r_pad_done) begin
                        if (r_wptr == 5'd16) begin
                            r_state <= ISSUE;
                        end else begin
                            r_buf[r_wptr[3:0]] <= SHA256_PAD_WORD;
                            r_wptr             <= r_wptr + 5'd1;
                            r_pad_done         <= 1'b1;
                        end
                    end else if (r_wptr <= 5'd14) begin
                        r_buf[14] <= w_len[63:32];
                        r_buf[15] <= w_len[31:0];
                        r_final   <= 1'b1;
                        r_state   <= ISSUE;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_ready) begin
                        r_core_init <= r_first;
                        r_core_next <= !r_first;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    // The core has not seen the pulse yet, so a stale digest_valid is ignored here.
                    if (core_ready && core_digest_valid && !w_pulse) begin
                        for (int i = 0; i < 16; i++)
                            r_buf[i] <= '0;
                        r_wptr  <= '0;
                        r_first <= 1'b0;
                        if (r_final) begin
                            r_msg_done  <= 1'b1;
                            r_bitlen    <= '0;
                            r_pad_done  <= 1'b0;
                            r_final     <= 1'b0;
                            r_last_seen <= 1'b0;
                            r_first     <= 1'b1;
                            r_in_ready  <= 1'b1;
                            r_state     <= FILL;
                        end else if (r_last_seen) begin
                            r_state <= PAD;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= FILL;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    always_comb begin
        core_block = '0;
        for (int i = 0; i < 16; i++)
            core_block[SHA256_BLOCK_W-1-32*i -: 32] = r_buf[i];
    end

    assign in_ready  = r_in_ready;
    assign core_init = r_core_init;
    assign core_next = r_core_next;
    assign msg_done  = r_msg_done;
    assign busy      = !(r_state == FILL && r_wptr == 5'd0 && r_first);

endmodule
